// File: rtl/key_repeat_ctrl_pkg.sv
// rtl/key_repeat_ctrl_pkg.sv - key FSM encodings, default timings and timer sizing
package key_repeat_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_st_e;

  localparam int unsigned DEF_HOLD_CNT   = 25_000_000;
  localparam int unsigned DEF_REPEAT_CNT = 10_000_000;

  // Bits needed to count 0 .. max(a, b)-1, never fewer than one.
  function automatic int unsigned timer_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - per-key edge decode, IDLE/HOLD/REPEAT FSM, timer and step pulse
module key_repeat
  import key_repeat_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CNT   = DEF_HOLD_CNT,
  parameter int unsigned REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_flag_i,
  input  logic key_state_i,
  output logic step_o,
  output logic start_o,
  output logic busy_o
);

  localparam int unsigned   TW        = timer_w(HOLD_CNT, REPEAT_CNT);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CNT - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CNT - 1);

  key_st_e       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          press_q, release_q;
  logic          step_q, step_d;

  // Edges are registered first so a flag at edge k yields a step at edge k+1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      press_q   <= key_flag_i & ~key_state_i;
      release_q <= key_flag_i & key_state_i;
      step_q    <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (press_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (release_q)                  state_d = ST_IDLE;
        else if (timer_q == HOLD_LAST)  state_d = ST_REPEAT;
        else                            timer_d = timer_q + 1'b1;
      end
      ST_REPEAT: begin
        if (release_q)                  state_d = ST_IDLE;
        else if (timer_q != REP_LAST)   timer_d = timer_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A release coinciding with a timer expiry suppresses that step.
  always_comb begin
    step_d = 1'b0;
    case (state_q)
      ST_IDLE:   step_d = press_q;
      ST_HOLD:   step_d = ~release_q & (timer_q == HOLD_LAST);
      ST_REPEAT: step_d = ~release_q & (timer_q == REP_LAST);
      default:   step_d = 1'b0;
    endcase
  end

  assign step_o  = step_q;
  assign start_o = press_q & (state_q == ST_IDLE);
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: rtl/key_repeat_ctrl.sv
// rtl/key_repeat_ctrl.sv - two-key step/auto-repeat controller with chord clear and LED count
module key_repeat_ctrl
  import key_repeat_ctrl_pkg::*;
#(
  parameter int unsigned LED_W      = 4,
  parameter int unsigned HOLD_CNT   = DEF_HOLD_CNT,
  parameter int unsigned REPEAT_CNT = DEF_REPEAT_CNT,
  parameter bit          WRAP       = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_flag0,
  input  logic             key_state0,
  input  logic             key_flag1,
  input  logic             key_state1,
  output logic [LED_W-1:0] led,
  output logic             chord,
  output logic             limit_hit
);

  localparam logic [LED_W-1:0] LED_MAX = '1;

  logic             step0, step1, start0, start1, busy0, busy1;
  logic             chord_set;
  logic             chord_q, chord_d;
  logic             limit_q, limit_d;
  logic [LED_W-1:0] led_q, led_d;

  key_repeat #(.HOLD_CNT(HOLD_CNT), .REPEAT_CNT(REPEAT_CNT)) u_key0 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_flag_i  (key_flag0),
    .key_state_i (key_state0),
    .step_o      (step0),
    .start_o     (start0),
    .busy_o      (busy0)
  );

  key_repeat #(.HOLD_CNT(HOLD_CNT), .REPEAT_CNT(REPEAT_CNT)) u_key1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_flag_i  (key_flag1),
    .key_state_i (key_state1),
    .step_o      (step1),
    .start_o     (start1),
    .busy_o      (busy1)
  );

  assign chord_set = (busy0 & busy1) | (start0 & start1);

  always_comb begin
    chord_d = chord_q;
    if (chord_set)            chord_d = 1'b1;
    else if (!busy0 && !busy1) chord_d = 1'b0;
  end

  // Chord beats any step; opposing steps in one cycle cancel.
  always_comb begin
    led_d   = led_q;
    limit_d = 1'b0;
    if (chord_set || chord_q) begin
      led_d = '0;
    end else if (step0 && !step1) begin
      if (led_q != LED_MAX) led_d = led_q + 1'b1;
      else if (WRAP)        led_d = '0;
      else                  limit_d = 1'b1;
    end else if (step1 && !step0) begin
      if (led_q != '0)      led_d = led_q - 1'b1;
      else if (WRAP)        led_d = LED_MAX;
      else                  limit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      chord_q <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      led_q   <= led_d;
      chord_q <= chord_d;
      limit_q <= limit_d;
    end
  end

  assign led       = led_q;
  assign chord     = chord_q;
  assign limit_hit = limit_q;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb/tb_key_repeat_ctrl.sv - bench for key_repeat_ctrl, wrapping and saturating builds side by side
`timescale 1ns/1ps
module tb_key_repeat_ctrl;

  localparam int H  = 10;
  localparam int R  = 4;
  localparam int NC = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kf0 = 1'b0, ks0 = 1'b1, kf1 = 1'b0, ks1 = 1'b1;
  logic [3:0] led_w, led_s;
  logic       chord_w, chord_s, lim_w, lim_s;

  always #5 clk = ~clk;

  key_repeat_ctrl #(.LED_W(4), .HOLD_CNT(H), .REPEAT_CNT(R), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .key_flag0(kf0), .key_state0(ks0),
    .key_flag1(kf1), .key_state1(ks1), .led(led_w), .chord(chord_w), .limit_hit(lim_w)
  );

  key_repeat_ctrl #(.LED_W(4), .HOLD_CNT(H), .REPEAT_CNT(R), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .key_flag0(kf0), .key_state0(ks0),
    .key_flag1(kf1), .key_state1(ks1), .led(led_s), .chord(chord_s), .limit_hit(lim_s)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int lim_cnt_w = 0, lim_cnt_s = 0;
  int e_led_w[NC+4], e_led_s[NC+4], e_chord[NC+4], e_lim_s[NC+4];

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Behavioural model: each key's step times follow from its age since press
  // (0, H, H+R, H+2R ...). Effects of inputs sampled at cycle t appear on the
  // outputs three cycles later; a same-cycle double press shows one cycle earlier.
  bit held[2];
  int age[2];
  bit lock;

  always @(posedge clk) begin
    bit step[2], started[2];
    bit fl, st;
    int d, nw, ns;
    if (cyc < NC) begin
      if (!rst_n) begin
        held[0] = 0; held[1] = 0; lock = 0;
        for (int v = cyc + 1; v <= cyc + 3; v++) begin
          e_led_w[v] = 0; e_led_s[v] = 0; e_chord[v] = 0; e_lim_s[v] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          fl = (k == 0) ? kf0 : kf1;
          st = (k == 0) ? ks0 : ks1;
          step[k] = 0; started[k] = 0;
          if (held[k] && fl && st) begin
            held[k] = 0;
          end else if (!held[k] && fl && !st) begin
            held[k] = 1; age[k] = 0; step[k] = 1; started[k] = 1;
          end else if (held[k]) begin
            age[k]++;
            step[k] = (age[k] >= H) && ((age[k] - H) % R == 0);
          end
        end
        if (started[0] && started[1]) begin
          e_led_w[cyc+2] = 0; e_led_s[cyc+2] = 0; e_chord[cyc+2] = 1; e_lim_s[cyc+2] = 0;
        end
        lock = (held[0] && held[1]) || (lock && (held[0] || held[1]));
        e_chord[cyc+3] = lock;
        e_lim_s[cyc+3] = 0;
        e_led_w[cyc+3] = e_led_w[cyc+2];
        e_led_s[cyc+3] = e_led_s[cyc+2];
        if (lock) begin
          e_led_w[cyc+3] = 0; e_led_s[cyc+3] = 0;
        end else if (step[0] != step[1]) begin
          d  = step[0] ? 1 : -1;
          nw = e_led_w[cyc+2] + d;
          ns = e_led_s[cyc+2] + d;
          e_led_w[cyc+3] = (nw + 16) % 16;
          if (ns < 0 || ns > 15) e_lim_s[cyc+3] = 1;
          else                   e_led_s[cyc+3] = ns;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (lim_w) lim_cnt_w++;
    if (lim_s) lim_cnt_s++;
    if (cyc < NC) begin
      check("led_wrap",   led_w,   rst_n ? e_led_w[cyc] : 0);
      check("led_sat",    led_s,   rst_n ? e_led_s[cyc] : 0);
      check("chord_wrap", chord_w, rst_n ? e_chord[cyc] : 0);
      check("chord_sat",  chord_s, rst_n ? e_chord[cyc] : 0);
      check("limit_wrap", lim_w,   0);
      check("limit_sat",  lim_s,   rst_n ? e_lim_s[cyc] : 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle debounced edge on the selected keys; rel=1 is a release.
  task automatic key_edge(input bit k0, input bit k1, input bit rel);
    if (k0) begin kf0 = 1'b1; ks0 = rel; end
    if (k1) begin kf1 = 1'b1; ks1 = rel; end
    tick();
    kf0 = 1'b0;
    kf1 = 1'b0;
  endtask

  task automatic tap(input bit k0, input bit k1);
    key_edge(k0, k1, 1'b0);
    tick(2);
    key_edge(k0, k1, 1'b1);
    tick(3);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(50);
    check("lit_idle_led",   led_w,   0);
    check("lit_idle_chord", chord_w, 0);
    check("lit_idle_limit", lim_cnt_w + lim_cnt_s, 0);

    key_edge(1, 0, 0); tick(4); key_edge(1, 0, 1); tick(10);
    check("lit_single_press", led_w, 1);

    reset_pulse(); tick(3);
    key_edge(1, 0, 0); tick(29); key_edge(1, 0, 1); tick(10);
    check("lit_repeat_wrap", led_w, 6);
    check("lit_repeat_sat",  led_s, 6);

    repeat (9) tap(1, 0);
    check("lit_at_max", led_s, 15);
    lim_cnt_w = 0; lim_cnt_s = 0;
    tap(1, 0);
    check("lit_wrap_up",    led_w, 0);
    check("lit_sat_up",     led_s, 15);
    check("lit_sat_pulses", lim_cnt_s, 1);
    check("lit_wrap_pulses", lim_cnt_w, 0);
    tap(0, 1);
    check("lit_wrap_down", led_w, 15);
    check("lit_sat_down",  led_s, 14);

    key_edge(1, 0, 0); tick(4);
    key_edge(0, 1, 0); tick(5);
    check("lit_chord_led", led_w, 0);
    check("lit_chord_on",  chord_w, 1);
    key_edge(0, 1, 1); tick(20);
    check("lit_chord_hold_led", led_s, 0);
    check("lit_chord_hold",     chord_s, 1);
    key_edge(1, 0, 1); tick(4);
    check("lit_chord_off", chord_w, 0);
    tap(0, 1);
    check("lit_post_chord_wrap", led_w, 15);
    check("lit_post_chord_sat",  led_s, 0);
    key_edge(1, 1, 0); tick(3);
    check("lit_both_led",   led_w, 0);
    check("lit_both_chord", chord_w, 1);
    key_edge(1, 1, 1); tick(5);

    key_edge(1, 0, 0); tick(16);
    check("lit_pre_reset", led_w, 3);
    rst_n = 1'b0;
    #2;
    check("lit_reset_led", led_w, 0);
    tick();
    rst_n = 1'b1;
    key_edge(1, 0, 1); tick(5);
    check("lit_late_release", led_w, 0);
    check("lit_late_chord",   chord_w, 0);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
